collision_score_engine: RTL and testbench

Parametrised successor to the single-lane collision/score updater for the lane-crossing game. Each clock it checks the player box against `NUM_LANES` moving bars and tracks lives and level internally. It also keeps a per-life high-water progress score and sequences respawn, level-up and game-over through a small FSM. It sits between the bar/player position generators and the VGA score/HUD logic.

---
 rtl/collision_score_engine.sv | 153 +++++++++++++++
 tb/tb_collision_score_engine.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/collision_score_engine.sv
// Multi-lane collision, progress and lives/level sequencer for the lane-crossing game.
// Registered outputs; RESPAWN/PLAY/OVER FSM gates when player inputs are evaluated.
module collision_score_engine #(
   parameter int NUM_LANES        = 6,
   parameter int W                = 10,
   parameter int LANE_X0          = 80,
   parameter int LANE_W           = 80,
   parameter int HALF_W           = 20,
   parameter int RESPAWN_CYCLES   = 2,
   parameter int LIVES            = 3,
   parameter int POINTS_PER_LEVEL = 5,
   parameter int MAX_LEVEL        = 15
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NUM_LANES*W-1:0] bar_pos,
   input  logic [NUM_LANES*W-1:0] bar_op,
   input  logic [W-1:0]         player_h,
   input  logic [W-1:0]         player_v,
   input  logic                 start,
   output logic [W-1:0]         points,
   output logic [3:0]           level,
   output logic [2:0]           lives,
   output logic                 reset_player,
   output logic                 hit,
   output logic [3:0]           hit_lane,
   output logic                 level_up,
   output logic                 game_over
);

   typedef enum logic [1:0] {RESPAWN, PLAY, OVER} state_t;

   localparam int CW    = W + 2;
   localparam int CNT_W = (RESPAWN_CYCLES > 1) ? $clog2(RESPAWN_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RESPAWN_CYCLES - 1);

   state_t           state, state_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic [2:0]       lives_n;
   logic [3:0]       level_n;
   logic [3:0]       prog, prog_n;
   logic [3:0]       lane_n;
   logic [W-1:0]     points_n;
   logic             hit_n, lu_n;

   logic [NUM_LANES-1:0] coll;
   logic [3:0]           first_lane;
   logic [3:0]           p;
   logic                 goal;
   logic [CW-1:0]        ph, pv, bp, bo;

   // Widened comparisons: every bound is an addition, so nothing wraps near 0.
   always_comb begin
      coll       = '0;
      first_lane = 4'd0;
      p          = 4'd0;
      bp         = '0;
      bo         = '0;
      ph         = CW'(player_h);
      pv         = CW'(player_v);
      goal       = ph >= CW'(LANE_X0 + NUM_LANES * LANE_W);
      for (int k = 0; k < NUM_LANES; k++) begin
         bp = CW'(bar_pos[k*W +: W]);
         bo = CW'(bar_op[k*W +: W]);
         coll[k] = (ph + CW'(HALF_W) > CW'(LANE_X0 + k * LANE_W))
                && (ph < CW'(LANE_X0 + (k + 1) * LANE_W + HALF_W))
                && (pv + CW'(HALF_W) > bp)
                && (pv < bp + bo + CW'(HALF_W));
         if (ph >= CW'(LANE_X0 + LANE_W / 2 + k * LANE_W))
            p = p + 4'd1;
      end
      for (int k = NUM_LANES - 1; k >= 0; k--)
         if (coll[k])
            first_lane = 4'(k);
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      lives_n = lives;
      level_n = level;
      prog_n  = prog;
      lane_n  = hit_lane;
      hit_n   = 1'b0;
      lu_n    = 1'b0;
      unique case (state)
         RESPAWN: begin
            if (cnt == '0)
               state_n = PLAY;
            else
               cnt_n = cnt - 1'b1;
         end
         PLAY: begin
            if (|coll) begin
               hit_n   = 1'b1;
               lane_n  = first_lane;
               lives_n = lives - 3'd1;
               prog_n  = 4'd0;
               cnt_n   = CNT_LOAD;
               state_n = (lives == 3'd1) ? OVER : RESPAWN;
            end else if (goal) begin
               lu_n    = 1'b1;
               level_n = (level == 4'(MAX_LEVEL)) ? level : level + 4'd1;
               prog_n  = 4'd0;
               cnt_n   = CNT_LOAD;
               state_n = RESPAWN;
            end else if (p > prog) begin
               prog_n = p;
            end
         end
         OVER: begin
            if (start) begin
               lives_n = 3'(LIVES);
               level_n = 4'd0;
               prog_n  = 4'd0;
               cnt_n   = CNT_LOAD;
               state_n = RESPAWN;
            end
         end
         default: state_n = RESPAWN;
      endcase
      points_n = W'(32'(level_n) * 32'(POINTS_PER_LEVEL) + 32'(prog_n));
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= RESPAWN;
         cnt          <= CNT_LOAD;
         lives        <= 3'(LIVES);
         level        <= 4'd0;
         prog         <= 4'd0;
         points       <= '0;
         hit          <= 1'b0;
         hit_lane     <= 4'd0;
         level_up     <= 1'b0;
         reset_player <= 1'b1;
         game_over    <= 1'b0;
      end else begin
         state        <= state_n;
         cnt          <= cnt_n;
         lives        <= lives_n;
         level        <= level_n;
         prog         <= prog_n;
         points       <= points_n;
         hit          <= hit_n;
         hit_lane     <= lane_n;
         level_up     <= lu_n;
         reset_player <= (state_n != PLAY);
         game_over    <= (state_n == OVER);
      end
   end

endmodule

// File: tb/tb_collision_score_engine.sv
// Directed bench for collision_score_engine with an expected-result queue.
module tb_collision_score_engine;

   localparam int NL = 6;
   localparam int W  = 10;

   logic            clk;
   logic            reset;
   logic [NL*W-1:0] bar_pos;
   logic [NL*W-1:0] bar_op;
   logic [W-1:0]    player_h;
   logic [W-1:0]    player_v;
   logic            start;
   logic [W-1:0]    points;
   logic [3:0]      level;
   logic [2:0]      lives;
   logic            reset_player;
   logic            hit;
   logic [3:0]      hit_lane;
   logic            level_up;
   logic            game_over;

   typedef struct {
      logic       hit;
      logic [3:0] lane;
      logic [2:0] lives;
      logic [3:0] level;
      logic [W-1:0] pts;
      logic       lu;
      logic       go;
      logic       rp;
   } exp_t;

   exp_t exp_q[$];
   int   n_asrt = 0;
   int   n_fail = 0;

   collision_score_engine dut (
      .clk(clk), .reset(reset),
      .bar_pos(bar_pos), .bar_op(bar_op),
      .player_h(player_h), .player_v(player_v),
      .start(start),
      .points(points), .level(level), .lives(lives),
      .reset_player(reset_player), .hit(hit),
      .hit_lane(hit_lane), .level_up(level_up),
      .game_over(game_over)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic cmp(input string tag, input string fld,
                      input logic [15:0] got, input logic [15:0] want);
      n_asrt++;
      assert (got === want) else begin
         n_fail++;
         $error("FAIL %s.%s observed=%0d expected=%0d", tag, fld, got, want);
      end
   endtask

   task automatic push(input logic h, input logic [3:0] ln,
                       input logic [2:0] lv, input logic [3:0] lvl,
                       input logic [W-1:0] pt, input logic lu,
                       input logic go, input logic rp);
      exp_t e;
      e.hit = h; e.lane = ln; e.lives = lv; e.level = lvl;
      e.pts = pt; e.lu = lu; e.go = go; e.rp = rp;
      exp_q.push_back(e);
   endtask

   task automatic check(input string tag);
      exp_t e;
      n_asrt++;
      assert (exp_q.size() != 0) else begin
         n_fail++;
         $error("FAIL %s.queue observed=empty expected=entry", tag);
         return;
      end
      e = exp_q.pop_front();
      cmp(tag, "hit",          16'(hit),          16'(e.hit));
      cmp(tag, "hit_lane",     16'(hit_lane),     16'(e.lane));
      cmp(tag, "lives",        16'(lives),        16'(e.lives));
      cmp(tag, "level",        16'(level),        16'(e.level));
      cmp(tag, "points",       16'(points),       16'(e.pts));
      cmp(tag, "level_up",     16'(level_up),     16'(e.lu));
      cmp(tag, "game_over",    16'(game_over),    16'(e.go));
      cmp(tag, "reset_player", 16'(reset_player), 16'(e.rp));
   endtask

   task automatic cyc(input string tag, input logic h, input logic [3:0] ln,
                      input logic [2:0] lv, input logic [3:0] lvl,
                      input logic [W-1:0] pt, input logic lu,
                      input logic go, input logic rp);
      push(h, ln, lv, lvl, pt, lu, go, rp);
      @(posedge clk);
      #1;
      check(tag);
   endtask

   task automatic bars_off();
      for (int k = 0; k < NL; k++) begin
         bar_pos[k*W +: W] = W'(1000);
         bar_op[k*W +: W]  = '0;
      end
   endtask

   task automatic set_bar(input int k, input int pos, input int len);
      bar_pos[k*W +: W] = W'(pos);
      bar_op[k*W +: W]  = W'(len);
   endtask

   task automatic player(input int h, input int v);
      player_h = W'(h);
      player_v = W'(v);
   endtask

   initial begin
      reset = 1'b0;
      start = 1'b0;
      bars_off();
      player(100, 100);
      #12;
      push(0, 0, 3, 0, 0, 0, 0, 1);
      check("reset_low");
      @(posedge clk);
      #1;
      push(0, 0, 3, 0, 0, 0, 0, 1);
      check("reset_low_clk");
      #6;
      reset = 1'b1;
      cyc("rel_1", 0, 0, 3, 0, 0, 0, 0, 1);
      cyc("rel_2", 0, 0, 3, 0, 0, 0, 0, 0);

      set_bar(2, 200, 40);
      player(280, 210);
      cyc("hit1", 1, 2, 2, 0, 0, 0, 0, 1);
      bars_off();
      player(100, 100);
      cyc("hit1_rsp1", 0, 2, 2, 0, 0, 0, 0, 1);
      cyc("hit1_rsp2", 0, 2, 2, 0, 0, 0, 0, 0);

      player(100, 100);
      cyc("prog_100", 0, 2, 2, 0, 0, 0, 0, 0);
      player(120, 100);
      cyc("prog_120", 0, 2, 2, 0, 1, 0, 0, 0);
      player(280, 100);
      cyc("prog_280", 0, 2, 2, 0, 3, 0, 0, 0);
      player(200, 100);
      start = 1'b1;
      cyc("prog_200", 0, 2, 2, 0, 3, 0, 0, 0);
      start = 1'b0;

      player(560, 100);
      cyc("goal", 0, 2, 2, 1, 5, 1, 0, 1);
      player(100, 100);
      cyc("goal_rsp1", 0, 2, 2, 1, 5, 0, 0, 1);
      cyc("goal_rsp2", 0, 2, 2, 1, 5, 0, 0, 0);

      set_bar(2, 200, 40);
      player(280, 180);
      cyc("edge_180", 0, 2, 2, 1, 8, 0, 0, 0);
      player(280, 181);
      cyc("edge_181", 1, 2, 1, 1, 5, 0, 0, 1);
      bars_off();
      player(100, 100);
      cyc("hit2_rsp1", 0, 2, 1, 1, 5, 0, 0, 1);
      cyc("hit2_rsp2", 0, 2, 1, 1, 5, 0, 0, 0);

      set_bar(5, 200, 40);
      player(560, 210);
      cyc("goal_hit", 1, 5, 0, 1, 5, 0, 1, 1);
      cyc("over_1", 0, 5, 0, 1, 5, 0, 1, 1);
      cyc("over_2", 0, 5, 0, 1, 5, 0, 1, 1);

      start = 1'b1;
      cyc("restart", 0, 5, 3, 0, 0, 0, 0, 1);
      start = 1'b0;
      bars_off();
      player(100, 100);
      cyc("rst_rsp1", 0, 5, 3, 0, 0, 0, 0, 1);
      cyc("rst_rsp2", 0, 5, 3, 0, 0, 0, 0, 0);

      n_asrt++;
      assert (exp_q.size() == 0) else begin
         n_fail++;
         $error("FAIL drain observed=%0d expected=0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_asrt, n_fail);
      $finish;
   end

endmodule
